// File: rtl/usb_clk_en_gen.sv
// usb_clk_en_gen
//   Multi-channel clock-enable generator. Each channel divides clk_i by a
//   run-time programmable divisor D. It produces a one-cycle enable strobe
//   (en_o) every D cycles and a toggle output (tgl_o) that divides by 2D.
//   The outputs start only after the PLL lock has been stable for LOCK_WAIT
//   cycles. A divisor change is held as pending and is applied at the
//   channel's terminal count, so no period is ever shortened or stretched.
//
// Ports
//   clk_i         single clock; all logic is rising-edge
//   reset_ni      asynchronous active-low reset
//   pll_locked_i  PLL lock, asynchronous to clk_i
//   div_we_i      divisor write strobe
//   div_ch_i      channel index for the write; indices >= NUM_CH are ignored
//   div_val_i     new divisor; 0 turns the channel off
//   sync_i        restart all channels in phase (only while running)
//   ready_o       outputs running
//   div_busy_o    per channel: a write is pending and not yet applied
//   en_o          per channel: one-cycle enable strobe
//   tgl_o         per channel: inverts on every en_o
module usb_clk_en_gen #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 8,
  parameter int DIV_RST   = 2,
  parameter int LOCK_WAIT = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              pll_locked_i,
  input  logic              div_we_i,
  input  logic [CH_W-1:0]   div_ch_i,
  input  logic [DIV_W-1:0]  div_val_i,
  input  logic              sync_i,
  output logic              ready_o,
  output logic [NUM_CH-1:0] div_busy_o,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] tgl_o
);

  localparam int WAIT_W = $clog2(LOCK_WAIT + 1);

  // Lock synchroniser and lock-stable wait counter
  logic              lk_meta_reg, lk_reg;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              run_reg, run_next;

  always_comb begin
    run_next      = run_reg;
    wait_cnt_next = wait_cnt_reg;
    if (!lk_reg) begin
      // Any cycle without lock stops the outputs and restarts the wait.
      run_next      = 1'b0;
      wait_cnt_next = '0;
    end else if (!run_reg) begin
      if (wait_cnt_reg == WAIT_W'(LOCK_WAIT - 1)) begin
        run_next = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lk_meta_reg  <= 1'b0;
      lk_reg       <= 1'b0;
      wait_cnt_reg <= '0;
      run_reg      <= 1'b0;
    end else begin
      lk_meta_reg  <= pll_locked_i;
      lk_reg       <= lk_meta_reg;
      wait_cnt_reg <= wait_cnt_next;
      run_reg      <= run_next;
    end
  end

  assign ready_o = run_reg;

  // Per-channel divider
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] act_d_reg, act_d_next;
      logic [DIV_W-1:0] pend_reg, pend_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             pend_vld_reg, pend_vld_next;
      logic             en_reg, en_next;
      logic             tgl_reg, tgl_next;
      logic             we_hit, sync_hit, apply;
      logic [DIV_W-1:0] d_use;

      always_comb begin
        // Out-of-range channel indices match no channel, so they are dropped.
        we_hit   = div_we_i && (div_ch_i == CH_W'(gi));
        sync_hit = sync_i && run_reg;
        // A pending divisor is only safe to adopt at a period boundary:
        // at terminal count, on sync, or when nothing is counting.
        apply    = pend_vld_reg &&
                   (!run_reg || (act_d_reg == '0) || (cnt_reg == '0) || sync_hit);
        d_use    = apply ? pend_reg : act_d_reg;

        act_d_next    = d_use;
        // A write in the apply cycle survives as the next pending value.
        pend_next     = we_hit ? div_val_i : pend_reg;
        pend_vld_next = we_hit || (pend_vld_reg && !apply);

        cnt_next = cnt_reg;
        en_next  = 1'b0;
        tgl_next = tgl_reg;

        if (!run_next) begin
          // Stopped: keep the counter preloaded so the first period after
          // ready rises is a full one.
          cnt_next = (d_use == '0) ? '0 : d_use - DIV_W'(1);
          tgl_next = 1'b0;
        end else if (sync_hit) begin
          cnt_next = (d_use == '0) ? '0 : d_use - DIV_W'(1);
          tgl_next = 1'b0;
        end else if (d_use == '0) begin
          cnt_next = '0;
        end else if (!run_reg || (cnt_reg == '0)) begin
          // Start of a period (ready rising or reload). When D=1 the
          // counter sits at 0, which strobes every cycle.
          cnt_next = d_use - DIV_W'(1);
          en_next  = (d_use == DIV_W'(1));
          tgl_next = tgl_reg ^ en_next;
        end else begin
          cnt_next = cnt_reg - DIV_W'(1);
          en_next  = (cnt_reg == DIV_W'(1));
          tgl_next = tgl_reg ^ en_next;
        end
      end

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          act_d_reg    <= DIV_W'(DIV_RST);
          pend_reg     <= '0;
          pend_vld_reg <= 1'b0;
          cnt_reg      <= '0;
          en_reg       <= 1'b0;
          tgl_reg      <= 1'b0;
        end else begin
          act_d_reg    <= act_d_next;
          pend_reg     <= pend_next;
          pend_vld_reg <= pend_vld_next;
          cnt_reg      <= cnt_next;
          en_reg       <= en_next;
          tgl_reg      <= tgl_next;
        end
      end

      assign en_o[gi]       = en_reg;
      assign tgl_o[gi]      = tgl_reg;
      assign div_busy_o[gi] = pend_vld_reg;
    end
  endgenerate

endmodule
